register_file_reader: RTL

- Read-side sequencer for the team's `register_file` block.
- On `start`, it sweeps a contiguous, wrapping address range on one read port of `register_file` and streams each word out on a valid/ready interface.
- Used for debug dumps, context save and bulk transfer of register contents to a downstream consumer.
- Sustains one word per cycle when `out_ready` is held high.

---
 rtl/register_file_reader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/register_file_reader.sv
// ============================================================================
//  Module      : register_file_reader
//  Description : Sweeps a wrapping address range on one register-file read
//                port and streams each word out on a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_reader #(
  parameter int WORD_LEN = 8,
  parameter int ADDR_LEN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_LEN-1:0] base_addr,
  input  logic [ADDR_LEN:0]   count,
  output logic [ADDR_LEN-1:0] read_addr,
  input  logic [WORD_LEN-1:0] read_data,
  output logic [WORD_LEN-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2
  } state_t;

  localparam logic [ADDR_LEN:0] c_rem_one = {{ADDR_LEN{1'b0}}, 1'b1};

  state_t              r_state;
  logic [ADDR_LEN-1:0] r_addr;
  logic [ADDR_LEN:0]   r_remaining;
  logic [WORD_LEN-1:0] r_out_data;
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_busy;
  logic                r_done;

  logic [ADDR_LEN-1:0] w_addr_next;
  logic                w_transfer;

  // Address register wraps naturally at 2**ADDR_LEN.
  assign w_addr_next = r_addr + 1'b1;
  assign w_transfer  = r_out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (count != '0) begin
              r_addr      <= base_addr;
              r_remaining <= count;
              r_busy      <= 1'b1;
              r_state     <= S_LOAD;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (abort) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_out_data  <= read_data;
            r_out_last  <= (r_remaining == c_rem_one);
            r_out_valid <= 1'b1;
            r_addr      <= w_addr_next;
            r_remaining <= r_remaining - 1'b1;
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          // Abort beats a same-cycle transfer: the presented word is dropped.
          if (abort) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else if (w_transfer) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_out_data  <= read_data;
              r_out_last  <= (r_remaining == c_rem_one);
              r_addr      <= w_addr_next;
              r_remaining <= r_remaining - 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign read_addr = r_addr;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

`default_nettype wire
